md_sequencer: RTL
=================

Name: md_sequencer

Overview:
Iterative multiply/divide sequencer that owns the HI/LO register pair and schedules the shared shift-add/shift-subtract engine for MULT, MULTU, DIV and DIVU. It sits beside the execute stage and takes operands already resolved by the decode/forwarding path. It drives a stall request into the hazard unit whenever an instruction needs HI/LO, or needs the engine, while the engine is busy.

Parameters:
DATA_WIDTH, 32, operand and HI/LO width; iteration count equals DATA_WIDTH.

Ports:
i_CLK  in  1  clock, rising edge
i_RST  in  1  asynchronous, active-low reset
i_StartE  in  1  mult/div instruction valid in execute
i_OpE  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
i_SrcAE  in  DATA_WIDTH  rs operand (multiplicand or dividend)
i_SrcBE  in  DATA_WIDTH  rt operand (multiplier or divisor)
i_FlushE  in  1  cancel the execute instruction and abort any running operation
i_ReadHiLoE  in  1  MFHI/MFLO in execute
i_MTHIE  in  1  write HI
i_MTLOE  in  1  write LO
i_WDataE  in  DATA_WIDTH  MTHI/MTLO data
o_Busy  out  1  engine running
o_StallMD  out  1  stall request to hazard unit
o_Done  out  1  one-cycle pulse when HI/LO are committed
o_DivZero  out  1  sticky; set by a divide with divisor 0, cleared by the next accepted start
o_HI  out  DATA_WIDTH  HI register
o_LO  out  DATA_WIDTH  LO register

Behaviour:
- Reset (async, i_RST=0): state IDLE; HI=0, LO=0, o_Busy=0, o_Done=0, o_DivZero=0, internal accumulators 0.
- States: IDLE, MUL, DIV, FIX.
- IDLE: i_StartE & ~i_FlushE accepts the operation at the next edge.
  - Latch |A| and |B| for signed ops, raw values for unsigned ops.
  - Latch the result sign: A[31]^B[31]. Latch the remainder sign: A[31].
  - Load counter = DATA_WIDTH-1.
  - Go to MUL (op[1]=0) or DIV (op[1]=1). o_Busy=1 from the next cycle.
- MUL: one radix-2 shift-add step per cycle into a 2*DATA_WIDTH product register; the counter decrements. Counter==0 -> FIX.
- DIV: one restoring step per cycle (shift remainder in, trial-subtract divisor, set quotient bit if no borrow). Counter==0 -> FIX.
- FIX (1 cycle):
  - Apply sign correction for signed ops. Product: negate if the sign differs. Quotient: negate if the sign differs. Remainder: takes the dividend's sign.
  - Commit at the end of FIX. MUL: HI=product[63:32], LO=product[31:0]. DIV: LO=quotient, HI=remainder.
  - o_Done=1 in the cycle after FIX commit; return to IDLE.
- Latency: start accepted at edge 0 -> HI/LO valid and o_Done high after edge DATA_WIDTH+1 (33 edges; 34 cycles including the start cycle).
- Divide by zero: run the full latency. Result is LO=all ones, HI=dividend (unsigned-op raw value; for signed ops, the original signed dividend). o_DivZero=1.
- o_StallMD (combinational) = o_Busy & (i_StartE | i_ReadHiLoE | i_MTHIE | i_MTLOE). It is also high in FIX, because o_Busy stays high through FIX.
- A stalled request is not performed. It is re-presented by the held pipeline and serviced in IDLE.
- i_MTHIE/i_MTLOE in IDLE: write i_WDataE at the next edge.
- Simultaneous i_StartE and MT* in IDLE: start wins and the MT write is dropped (cannot occur legally).
- i_FlushE while busy: abort to IDLE at the next edge. HI/LO and o_DivZero are unchanged and there is no o_Done pulse.
- i_FlushE with i_StartE in IDLE: the start is not accepted.
- Reset mid-operation: immediate return to the reset values above.
- o_HI/o_LO always reflect the committed registers, never intermediate values.

Decomposition:
- Shared package: MD op encodings (MD_MULT=2'b00, MD_MULTU=2'b01, MD_DIV=2'b10, MD_DIVU=2'b11) and state encodings.
- One natural sub-module: md_step_unit. It is the combinational single-iteration shift-add / restoring-subtract datapath slice, instantiated once; the FSM, counter, sign fix and HI/LO registers stay in md_sequencer.

Test Plan:
- MULT A=0xFFFFFFFD (-3), B=7 -> after 33 edges HI=0xFFFFFFFF, LO=0xFFFFFFEB, o_Done pulses once, o_Busy drops the same cycle.
- DIVU A=100, B=7 -> LO=14, HI=2. Then DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU A=0x12345678, B=0 -> LO=0xFFFFFFFF, HI=0x12345678, o_DivZero=1. The next MULTU 3*4 clears it, giving LO=12, HI=0.
- During a MULTU, assert i_ReadHiLoE at cycle 5 -> o_StallMD=1 until o_Busy=0, and HI/LO are unchanged until commit. An MTLO 0xAA in IDLE -> LO=0xAA next cycle.
- Start DIV, assert i_FlushE at cycle 10 -> IDLE next edge, no o_Done, HI/LO hold prior values. A fresh start is accepted next cycle.
- Assert i_RST=0 asynchronously mid-MULT -> HI=LO=0, o_Busy=0 without waiting for a clock edge.

Source files
------------

// File: rtl/md_sequencer_pkg.sv
// md_sequencer_pkg: shared opcode and state encodings for the multiply/divide sequencer.
package md_sequencer_pkg;
   typedef enum logic [1:0] {
      MD_MULT  = 2'b00,
      MD_MULTU = 2'b01,
      MD_DIV   = 2'b10,
      MD_DIVU  = 2'b11
   } md_op_e;
   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_MUL  = 2'b01,
      S_DIV  = 2'b10,
      S_FIX  = 2'b11
   } md_state_e;
endpackage

// File: rtl/md_sequencer_step_unit.sv
// md_step_unit: one radix-2 shift-add or restoring shift-subtract iteration on a {hi,lo} accumulator.
module md_step_unit #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                      i_Div,
   input  logic [2*DATA_WIDTH-1:0]   i_Acc,
   input  logic [DATA_WIDTH-1:0]     i_Operand,
   output logic [2*DATA_WIDTH-1:0]   o_Acc
);
   localparam int W = DATA_WIDTH;
   logic [W:0]   w_sum;
   logic         w_fit;
   logic [W-1:0] w_rem;
   always_comb begin
      w_sum = {1'b0, i_Acc[2*W-1:W]} + (i_Acc[0] ? {1'b0, i_Operand} : '0);
      // the shifted partial remainder is W+1 bits wide before the trial subtract
      w_fit = i_Acc[2*W-1:W-1] >= {1'b0, i_Operand};
      w_rem = w_fit ? i_Acc[2*W-2:W-1] - i_Operand : i_Acc[2*W-2:W-1];
      o_Acc = i_Div ? {w_rem, i_Acc[W-2:0], w_fit} : {w_sum, i_Acc[W-1:1]};
   end
endmodule

// File: rtl/md_sequencer.sv
// md_sequencer: iterative MULT/MULTU/DIV/DIVU engine owning HI/LO, with stall request to the hazard unit.
module md_sequencer
   import md_sequencer_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  i_CLK,
   input  logic                  i_RST,
   input  logic                  i_StartE,
   input  logic [1:0]            i_OpE,
   input  logic [DATA_WIDTH-1:0] i_SrcAE,
   input  logic [DATA_WIDTH-1:0] i_SrcBE,
   input  logic                  i_FlushE,
   input  logic                  i_ReadHiLoE,
   input  logic                  i_MTHIE,
   input  logic                  i_MTLOE,
   input  logic [DATA_WIDTH-1:0] i_WDataE,
   output logic                  o_Busy,
   output logic                  o_StallMD,
   output logic                  o_Done,
   output logic                  o_DivZero,
   output logic [DATA_WIDTH-1:0] o_HI,
   output logic [DATA_WIDTH-1:0] o_LO
);
   localparam int W  = DATA_WIDTH;
   localparam int CW = $clog2(W);
   md_state_e       r_state;
   logic [CW-1:0]   r_count;
   logic [2*W-1:0]  r_acc;
   logic [W-1:0]    r_opb;
   logic            r_signed, r_sign, r_rsign, r_bzero, r_div;
   logic [W-1:0]    r_hi, r_lo;
   logic            r_done, r_divzero;
   logic            w_signed, w_accept;
   logic [W-1:0]    w_abs_a, w_abs_b;
   logic [2*W-1:0]  w_step, w_prod;
   logic [W-1:0]    w_quo, w_rem;
   assign w_signed = ~i_OpE[0];
   assign w_accept = i_StartE & ~i_FlushE;
   assign w_abs_a  = (w_signed & i_SrcAE[W-1]) ? -i_SrcAE : i_SrcAE;
   assign w_abs_b  = (w_signed & i_SrcBE[W-1]) ? -i_SrcBE : i_SrcBE;
   assign w_prod   = (r_signed & r_sign)  ? -r_acc          : r_acc;
   assign w_quo    = (r_signed & r_sign)  ? -r_acc[W-1:0]   : r_acc[W-1:0];
   // remainder follows the dividend sign; on divide-by-zero this restores the original dividend
   assign w_rem    = (r_signed & r_rsign) ? -r_acc[2*W-1:W] : r_acc[2*W-1:W];
   md_step_unit #(.DATA_WIDTH(W)) u_step (
      .i_Div     (r_state == S_DIV),
      .i_Acc     (r_acc),
      .i_Operand (r_opb),
      .o_Acc     (w_step)
   );
   always_ff @(posedge i_CLK or negedge i_RST) begin
      if (!i_RST) begin
         r_state   <= S_IDLE;
         r_count   <= '0;
         r_acc     <= '0;
         r_opb     <= '0;
         r_signed  <= 1'b0;
         r_sign    <= 1'b0;
         r_rsign   <= 1'b0;
         r_bzero   <= 1'b0;
         r_div     <= 1'b0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_done    <= 1'b0;
         r_divzero <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_state   <= i_OpE[1] ? S_DIV : S_MUL;
                  r_count   <= CW'(W - 1);
                  r_acc     <= {{W{1'b0}}, i_OpE[1] ? w_abs_a : w_abs_b};
                  r_opb     <= i_OpE[1] ? w_abs_b : w_abs_a;
                  r_signed  <= w_signed;
                  r_sign    <= i_SrcAE[W-1] ^ i_SrcBE[W-1];
                  r_rsign   <= i_SrcAE[W-1];
                  r_bzero   <= i_SrcBE == '0;
                  r_div     <= i_OpE[1];
                  r_divzero <= 1'b0;
               end else if (!i_FlushE) begin
                  if (i_MTHIE) r_hi <= i_WDataE;
                  if (i_MTLOE) r_lo <= i_WDataE;
               end
            end
            S_MUL, S_DIV: begin
               if (i_FlushE) r_state <= S_IDLE;
               else begin
                  r_acc   <= w_step;
                  r_count <= r_count - 1'b1;
                  if (r_count == '0) r_state <= S_FIX;
               end
            end
            S_FIX: begin
               r_state <= S_IDLE;
               if (!i_FlushE) begin
                  r_done <= 1'b1;
                  if (r_div) begin
                     r_lo      <= r_bzero ? '1 : w_quo;
                     r_hi      <= w_rem;
                     r_divzero <= r_bzero;
                  end else begin
                     r_hi <= w_prod[2*W-1:W];
                     r_lo <= w_prod[W-1:0];
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
   assign o_Busy    = r_state != S_IDLE;
   assign o_StallMD = o_Busy & (i_StartE | i_ReadHiLoE | i_MTHIE | i_MTLOE);
   assign o_Done    = r_done;
   assign o_DivZero = r_divzero;
   assign o_HI      = r_hi;
   assign o_LO      = r_lo;
endmodule
